// File: rtl/uart_wb_master_pkg.sv
//==============================================================================
// Module   : uart_wb_master_pkg
// Brief    : MiniUART register offsets, default baud divisors, LSR bit fields.
// Revision : 1.0
//==============================================================================
`default_nettype none

package uart_wb_master_pkg;

   localparam logic [2:0]  OFF_UART_DATA = 3'd0;
   localparam logic [2:0]  OFF_UART_LSR  = 3'd1;
   localparam logic [2:0]  OFF_UART_DIVR = 3'd2;
   localparam logic [2:0]  OFF_UART_DIVT = 3'd3;

   localparam logic [31:0] BAUD_RCV_9600 = 32'd326;
   localparam logic [31:0] BAUD_SND_9600 = 32'd5208;

   localparam int          LSR_RS = 0;
   localparam int          LSR_TS = 5;

   localparam logic        PRIO_RX = 1'b0;
   localparam logic        PRIO_TX = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_wb_rx_hold.sv
//==============================================================================
// Module   : uart_wb_rx_hold
// Brief    : Single-entry received-byte holding register with valid/ready.
// Revision : 1.0
//==============================================================================
`default_nettype none

module uart_wb_rx_hold (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] din,
   input  logic       ready,
   output logic       valid,
   output logic [7:0] dout
);

   // load is only issued while empty, so it never collides with a consume
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         dout  <= 8'h00;
      end else if (load) begin
         valid <= 1'b1;
         dout  <= din;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_wb_master.sv
//==============================================================================
// Module   : uart_wb_master
// Brief    : Wishbone master driving a MiniUART; exposes TX/RX byte streams.
// Revision : 1.0
//==============================================================================
`default_nettype none

module uart_wb_master
   import uart_wb_master_pkg::*;
#(
   parameter logic [31:0] DIVR_INIT = BAUD_RCV_9600,
   parameter logic [31:0] DIVT_INIT = BAUD_SND_9600,
   parameter int unsigned TX_GUARD  = 4
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   output logic [4:2]  ADD_O,
   output logic [31:0] DAT_O,
   input  logic [31:0] DAT_I,
   output logic        STB_O,
   output logic        WE_O,
   input  logic        ACK_I,
   input  logic        tx_valid,
   input  logic [7:0]  tx_byte,
   output logic        tx_ready,
   output logic        rx_valid,
   output logic [7:0]  rx_byte,
   input  logic        rx_ready
);

   typedef enum logic [2:0] {
      ST_INIT_R  = 3'd0,
      ST_INIT_T  = 3'd1,
      ST_POLL    = 3'd2,
      ST_RD_DATA = 3'd3,
      ST_RX_REL  = 3'd4,
      ST_WR_DATA = 3'd5
   } state_t;

   localparam logic [3:0] GUARD_LOAD = 4'(TX_GUARD);

   state_t      state, state_nxt;
   logic        stb, stb_nxt;
   logic        we, we_nxt;
   logic [2:0]  adr, adr_nxt;
   logic [31:0] dat, dat_nxt;
   logic [3:0]  guard, guard_nxt;
   logic        prio, prio_nxt;
   logic        req_we;
   logic [2:0]  req_adr;
   logic [31:0] req_dat;
   logic        rx_pend, tx_pend, rx_load;
   logic        unused_dat;

   assign unused_dat = ^DAT_I[31:8];

   assign ADD_O = adr;
   assign DAT_O = dat;
   assign STB_O = stb;
   assign WE_O  = we;

   // guard hides the stale ts=1 the slave reports right after a DATA write
   assign rx_pend = DAT_I[LSR_RS] & ~rx_valid;
   assign tx_pend = DAT_I[LSR_TS] & tx_valid & (guard == 4'd0);

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state <= ST_INIT_R;
         stb   <= 1'b0;
         we    <= 1'b0;
         adr   <= 3'd0;
         dat   <= 32'd0;
         guard <= 4'd0;
         prio  <= PRIO_RX;
      end else begin
         state <= state_nxt;
         stb   <= stb_nxt;
         we    <= we_nxt;
         adr   <= adr_nxt;
         dat   <= dat_nxt;
         guard <= guard_nxt;
         prio  <= prio_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      stb_nxt   = stb;
      we_nxt    = we;
      adr_nxt   = adr;
      dat_nxt   = dat;
      prio_nxt  = prio;
      guard_nxt = (guard != 4'd0) ? guard - 4'd1 : guard;
      rx_load   = 1'b0;
      tx_ready  = 1'b0;
      req_we    = 1'b0;
      req_adr   = OFF_UART_LSR;
      req_dat   = 32'd0;

      case (state)
         ST_INIT_R:  begin req_we = 1'b1; req_adr = OFF_UART_DIVR; req_dat = DIVR_INIT; end
         ST_INIT_T:  begin req_we = 1'b1; req_adr = OFF_UART_DIVT; req_dat = DIVT_INIT; end
         ST_RD_DATA: begin req_adr = OFF_UART_DATA; end
         ST_RX_REL:  begin req_we = 1'b1; req_adr = OFF_UART_LSR; end
         ST_WR_DATA: begin req_we = 1'b1; req_adr = OFF_UART_DATA; req_dat = {24'd0, tx_byte}; end
         default:    begin req_adr = OFF_UART_LSR; end
      endcase

      // a cycle always ends with STB low for one clock before the next launch
      if (!stb) begin
         stb_nxt = 1'b1;
         we_nxt  = req_we;
         adr_nxt = req_adr;
         dat_nxt = req_dat;
      end else if (ACK_I) begin
         stb_nxt = 1'b0;
         we_nxt  = 1'b0;
         case (state)
            ST_INIT_R: state_nxt = ST_INIT_T;
            ST_INIT_T: state_nxt = ST_POLL;
            ST_POLL: begin
               if (rx_pend && tx_pend) begin
                  state_nxt = (prio == PRIO_RX) ? ST_RD_DATA : ST_WR_DATA;
                  prio_nxt  = ~prio;
               end else if (rx_pend) begin
                  state_nxt = ST_RD_DATA;
               end else if (tx_pend) begin
                  state_nxt = ST_WR_DATA;
               end
            end
            ST_RD_DATA: begin
               rx_load   = 1'b1;
               state_nxt = ST_RX_REL;
            end
            ST_RX_REL: state_nxt = ST_POLL;
            ST_WR_DATA: begin
               tx_ready  = 1'b1;
               guard_nxt = GUARD_LOAD;
               state_nxt = ST_POLL;
            end
            default: state_nxt = ST_INIT_R;
         endcase
      end
   end

   uart_wb_rx_hold u_rx_hold (
      .clk   (CLK_I),
      .rst_n (RST_I),
      .load  (rx_load),
      .din   (DAT_I[7:0]),
      .ready (rx_ready),
      .valid (rx_valid),
      .dout  (rx_byte)
   );

endmodule

`default_nettype wire

// File: tb/tb_uart_wb_master.sv
//==============================================================================
// Module   : tb_uart_wb_master
// Brief    : Scoreboard bench for uart_wb_master against a behavioural MiniUART.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_wb_master;
   import uart_wb_master_pkg::*;

   localparam logic [31:0] DIVR_V  = 32'h0000_0145;
   localparam logic [31:0] DIVT_V  = 32'h0000_1458;
   localparam int          TX_TIME = 12;
   localparam int          TS_LAG  = 2;

   typedef struct {
      int          cyc;
      logic        we;
      logic [2:0]  adr;
      logic [31:0] dat;
   } bus_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:2]  adr;
   logic [31:0] dat_o, dat_i;
   logic        stb, we, ack;
   logic        tx_valid = 1'b0;
   logic [7:0]  tx_byte = 8'h00;
   logic        tx_ready, rx_valid, rx_ready = 1'b0;
   logic [7:0]  rx_byte;

   int n_pass = 0, n_total = 0;
   int n_dbl = 0, n_bad_pre = 0, n_rd_full = 0, n_txr = 0, n_rxv = 0, cyc = 0;
   bit prev_lsr_ts1 = 1'b0;

   bus_t        bus_log[$];
   bit          grant_log[$];
   logic [31:0] tx_exp[$], tx_obs[$];
   logic [7:0]  rx_exp[$], rx_obs[$], uart_in[$];

   logic        m_rs = 1'b0;
   logic [7:0]  m_rx_buf = 8'h00;
   int          m_tx_cnt = 0;
   logic        m_ts;

   always #5 clk = ~clk;

   uart_wb_master #(.DIVR_INIT(DIVR_V), .DIVT_INIT(DIVT_V), .TX_GUARD(4)) dut (
      .CLK_I(clk), .RST_I(rst_n), .ADD_O(adr), .DAT_O(dat_o), .DAT_I(dat_i),
      .STB_O(stb), .WE_O(we), .ACK_I(ack),
      .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
      .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready)
   );

   // behavioural MiniUART slave: combinational ACK, ts stays stale for TS_LAG cycles
   assign ack  = stb;
   assign m_ts = !(m_tx_cnt > 0 && m_tx_cnt <= TX_TIME);

   always_comb begin
      dat_i = 32'd0;
      if (adr == OFF_UART_LSR) begin
         dat_i[LSR_RS] = m_rs;
         dat_i[LSR_TS] = m_ts;
      end else if (adr == OFF_UART_DATA) begin
         dat_i[7:0] = m_rx_buf;
      end
   end

   always @(posedge clk) begin
      if (m_tx_cnt > 0) m_tx_cnt <= m_tx_cnt - 1;
      if (stb && ack && we && adr == OFF_UART_DATA) begin
         if (m_tx_cnt != 0) n_dbl <= n_dbl + 1;
         m_tx_cnt <= TS_LAG + TX_TIME;
         tx_obs.push_back(dat_o);
      end
      if (stb && ack && we && adr == OFF_UART_LSR) m_rs <= 1'b0;
      if (!m_rs && uart_in.size() > 0) begin
         m_rx_buf <= uart_in.pop_front();
         m_rs     <= 1'b1;
      end
   end

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (stb && ack) begin
         bus_log.push_back(bus_t'{cyc: cyc, we: we, adr: adr, dat: (we ? dat_o : dat_i)});
         prev_lsr_ts1 <= !we && adr == OFF_UART_LSR && dat_i[LSR_TS];
         if (!we && adr == OFF_UART_DATA) begin
            grant_log.push_back(1'b0);
            if (rx_valid) n_rd_full <= n_rd_full + 1;
         end
         if (we && adr == OFF_UART_DATA) begin
            grant_log.push_back(1'b1);
            if (!prev_lsr_ts1) n_bad_pre <= n_bad_pre + 1;
         end
      end
      if (tx_ready) n_txr <= n_txr + 1;
      if (rx_valid) n_rxv <= n_rxv + 1;
      if (rx_valid && rx_ready) rx_obs.push_back(rx_byte);
   end

   task automatic wait_log(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (bus_log.size() >= n) ok = 1'b1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output bit ok);
      tx_exp.push_back({24'd0, b});
      tx_byte  = b;
      tx_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (tx_ready) ok = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      int base;
      bit ok;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if (stb !== 1'b0 || we !== 1'b0) $display("FAIL reset_stb_we: got stb=%b we=%b want 0 0", stb, we); else n_pass++;
      n_total++;
      if (adr !== 3'd0 || dat_o !== 32'd0) $display("FAIL reset_adr_dat: got %h %h want 0 0", adr, dat_o); else n_pass++;
      n_total++;
      if (tx_ready !== 1'b0 || rx_valid !== 1'b0 || rx_byte !== 8'h00)
         $display("FAIL reset_streams: got txr=%b rxv=%b rxb=%h want 0 0 00", tx_ready, rx_valid, rx_byte);
      else n_pass++;
      base = bus_log.size();
      rst_n = 1'b1;
      wait_log(base + 4, ok);
      n_total++;
      if (!ok) $display("FAIL init_timeout: got %0d bus cycles want %0d", bus_log.size() - base, 4); else n_pass++;
      if (ok) begin
         n_total++;
         if (!(bus_log[base].we && bus_log[base].adr == OFF_UART_DIVR && bus_log[base].dat == DIVR_V))
            $display("FAIL init_divr: got we=%b adr=%0d dat=%h want 1 %0d %h", bus_log[base].we, bus_log[base].adr, bus_log[base].dat, OFF_UART_DIVR, DIVR_V);
         else n_pass++;
         n_total++;
         if (!(bus_log[base+1].we && bus_log[base+1].adr == OFF_UART_DIVT && bus_log[base+1].dat == DIVT_V))
            $display("FAIL init_divt: got we=%b adr=%0d dat=%h want 1 %0d %h", bus_log[base+1].we, bus_log[base+1].adr, bus_log[base+1].dat, OFF_UART_DIVT, DIVT_V);
         else n_pass++;
         n_total++;
         if (bus_log[base+2].we || bus_log[base+2].adr != OFF_UART_LSR || bus_log[base+3].we || bus_log[base+3].adr != OFF_UART_LSR)
            $display("FAIL init_poll: got adr=%0d,%0d want LSR reads", bus_log[base+2].adr, bus_log[base+3].adr);
         else n_pass++;
         n_total++;
         if (bus_log[base+3].cyc - bus_log[base+2].cyc != 2 || bus_log[base+1].cyc - bus_log[base].cyc != 2)
            $display("FAIL init_spacing: got %0d,%0d want 2,2", bus_log[base+1].cyc - bus_log[base].cyc, bus_log[base+3].cyc - bus_log[base+2].cyc);
         else n_pass++;
      end
      n_total++;
      if (rx_valid !== 1'b0 || tx_ready !== 1'b0) $display("FAIL idle_streams: got rxv=%b txr=%b want 0 0", rx_valid, tx_ready); else n_pass++;
   endtask

   task automatic test_tx_single();
      bit ok;
      int txr0;
      txr0 = n_txr;
      send_byte(8'h55, ok);
      tx_valid = 1'b0;
      n_total++;
      if (!ok) $display("FAIL tx_single_accept: got no tx_ready want accept"); else n_pass++;
      repeat (40) @(negedge clk);
      n_total++;
      if (n_txr - txr0 != 1) $display("FAIL tx_single_ready_len: got %0d want 1", n_txr - txr0); else n_pass++;
      n_total++;
      if (tx_obs.size() != 1) $display("FAIL tx_single_writes: got %0d want 1", tx_obs.size());
      else begin
         if (tx_obs.pop_front() !== tx_exp.pop_front()) $display("FAIL tx_single_data: wrong DATA write value");
         else n_pass++;
      end
      n_total++;
      if (n_dbl != 0) $display("FAIL tx_single_dbl: got %0d early writes want 0", n_dbl); else n_pass++;
   endtask

   task automatic test_back_to_back();
      bit ok, all_ok;
      int txr0;
      logic [31:0] e, o;
      txr0 = n_txr;
      all_ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send_byte(8'h41 + 8'(i), ok);
         all_ok &= ok;
      end
      tx_valid = 1'b0;
      n_total++;
      if (!all_ok) $display("FAIL b2b_accept: got a byte not accepted want 3 accepts"); else n_pass++;
      repeat (40) @(negedge clk);
      n_total++;
      if (tx_obs.size() != 3) $display("FAIL b2b_count: got %0d want 3", tx_obs.size()); else n_pass++;
      while (tx_obs.size() > 0 && tx_exp.size() > 0) begin
         e = tx_exp.pop_front();
         o = tx_obs.pop_front();
         n_total++;
         if (o !== e) $display("FAIL b2b_data: got %h want %h", o, e); else n_pass++;
      end
      n_total++;
      if (n_dbl != 0 || n_bad_pre != 0) $display("FAIL b2b_guard: got dbl=%0d bad_pre=%0d want 0 0", n_dbl, n_bad_pre); else n_pass++;
      n_total++;
      if (n_txr - txr0 != 3) $display("FAIL b2b_ready_pulses: got %0d want 3", n_txr - txr0); else n_pass++;
   endtask

   task automatic test_rx_single();
      int base, rxv0, k;
      bit ok;
      rx_ready = 1'b1;
      base = bus_log.size();
      rxv0 = n_rxv;
      rx_exp.push_back(8'hA7);
      uart_in.push_back(8'hA7);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (rx_obs.size() > 0) ok = 1'b1;
      end
      repeat (10) @(negedge clk);
      n_total++;
      if (!ok) $display("FAIL rx_single_timeout: got no rx handshake want A7");
      else if (rx_obs.pop_front() !== rx_exp.pop_front()) $display("FAIL rx_single_data: wrong rx_byte want A7");
      else n_pass++;
      n_total++;
      if (n_rxv - rxv0 != 1) $display("FAIL rx_single_valid_len: got %0d want 1", n_rxv - rxv0); else n_pass++;
      k = -1;
      for (int i = base; i < bus_log.size(); i++)
         if (k < 0 && !bus_log[i].we && bus_log[i].adr == OFF_UART_DATA) k = i;
      n_total++;
      if (k < base + 1 || k + 2 >= bus_log.size()) $display("FAIL rx_seq_found: got index %0d want DATA read", k);
      else begin
         n_pass++;
         n_total++;
         if (bus_log[k-1].we || bus_log[k-1].adr != OFF_UART_LSR || !bus_log[k-1].dat[LSR_RS])
            $display("FAIL rx_seq_pre: got we=%b adr=%0d rs=%b want LSR read rs=1", bus_log[k-1].we, bus_log[k-1].adr, bus_log[k-1].dat[LSR_RS]);
         else n_pass++;
         n_total++;
         if (!bus_log[k+1].we || bus_log[k+1].adr != OFF_UART_LSR)
            $display("FAIL rx_seq_rel: got we=%b adr=%0d want LSR write", bus_log[k+1].we, bus_log[k+1].adr);
         else n_pass++;
         n_total++;
         if (bus_log[k+2].we || bus_log[k+2].adr != OFF_UART_LSR || bus_log[k+2].dat[LSR_RS])
            $display("FAIL rx_seq_post: got we=%b adr=%0d rs=%b want LSR read rs=0", bus_log[k+2].we, bus_log[k+2].adr, bus_log[k+2].dat[LSR_RS]);
         else n_pass++;
      end
   endtask

   task automatic test_rx_backpressure();
      int rd0;
      bit ok;
      rx_ready = 1'b0;
      rd0 = n_rd_full;
      rx_exp.push_back(8'h11);
      rx_exp.push_back(8'h22);
      uart_in.push_back(8'h11);
      uart_in.push_back(8'h22);
      repeat (80) @(negedge clk);
      n_total++;
      if (rx_valid !== 1'b1 || rx_byte !== 8'h11) $display("FAIL bp_hold: got rxv=%b rxb=%h want 1 11", rx_valid, rx_byte); else n_pass++;
      n_total++;
      if (n_rd_full != rd0) $display("FAIL bp_no_read: got %0d DATA reads while full want 0", n_rd_full - rd0); else n_pass++;
      n_total++;
      if (m_rs !== 1'b1) $display("FAIL bp_waiting: got rs=%b want 1", m_rs); else n_pass++;
      @(posedge clk); #1 rx_ready = 1'b1;
      @(posedge clk); #1 rx_ready = 1'b0;
      n_total++;
      if (rx_obs.size() != 1) $display("FAIL bp_first_count: got %0d want 1", rx_obs.size());
      else if (rx_obs.pop_front() !== rx_exp.pop_front()) $display("FAIL bp_first_data: wrong byte want 11");
      else n_pass++;
      rx_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (rx_obs.size() > 0) ok = 1'b1;
      end
      n_total++;
      if (!ok) $display("FAIL bp_second_timeout: got no byte want 22");
      else if (rx_obs.pop_front() !== rx_exp.pop_front()) $display("FAIL bp_second_data: wrong byte want 22");
      else n_pass++;
   endtask

   task automatic test_arbitration();
      bit ok;
      logic [7:0] e, o;
      @(posedge clk); #1;
      rst_n = 1'b0;
      grant_log.delete();
      rx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rx_exp.push_back(8'h31 + 8'(i));
         uart_in.push_back(8'h31 + 8'(i));
      end
      tx_exp.push_back(32'h0000_005A);
      tx_byte  = 8'h5A;
      tx_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (tx_ready) ok = 1'b1;
      end
      @(posedge clk); #1 tx_valid = 1'b0;
      n_total++;
      if (!ok) $display("FAIL arb_tx_accept: got no tx_ready want accept"); else n_pass++;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (grant_log.size() >= 3 && rx_obs.size() >= 3) ok = 1'b1;
      end
      n_total++;
      if (!ok) $display("FAIL arb_timeout: got %0d grants %0d rx want 3 3", grant_log.size(), rx_obs.size());
      else begin
         n_pass++;
         n_total++;
         if (grant_log[0] !== 1'b0 || grant_log[1] !== 1'b1 || grant_log[2] !== 1'b0)
            $display("FAIL arb_order: got %b%b%b (0=RX 1=TX) want 010", grant_log[0], grant_log[1], grant_log[2]);
         else n_pass++;
      end
      while (rx_obs.size() > 0 && rx_exp.size() > 0) begin
         e = rx_exp.pop_front();
         o = rx_obs.pop_front();
         n_total++;
         if (o !== e) $display("FAIL arb_rx_data: got %h want %h", o, e); else n_pass++;
      end
      repeat (30) @(negedge clk);
      n_total++;
      if (tx_obs.size() != 1) $display("FAIL arb_tx_count: got %0d want 1", tx_obs.size());
      else if (tx_obs.pop_front() !== tx_exp.pop_front()) $display("FAIL arb_tx_data: wrong DATA write want 5A");
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit ok;
      int base;
      tx_byte  = 8'h99;
      tx_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (stb && we && adr == OFF_UART_DATA) ok = 1'b1;
      end
      rst_n = 1'b0;
      #1;
      n_total++;
      if (!ok) $display("FAIL mid_wr_timeout: got no DATA write strobe want one"); else n_pass++;
      n_total++;
      if (stb !== 1'b0 || tx_ready !== 1'b0) $display("FAIL mid_abort: got stb=%b txr=%b want 0 0", stb, tx_ready); else n_pass++;
      tx_valid = 1'b0;
      base = bus_log.size();
      @(posedge clk); #1 rst_n = 1'b1;
      wait_log(base + 1, ok);
      n_total++;
      if (!ok) $display("FAIL mid_restart_timeout: got no bus cycle want DIVR write");
      else if (!(bus_log[base].we && bus_log[base].adr == OFF_UART_DIVR && bus_log[base].dat == DIVR_V))
         $display("FAIL mid_restart: got we=%b adr=%0d dat=%h want DIVR write", bus_log[base].we, bus_log[base].adr, bus_log[base].dat);
      else n_pass++;
      repeat (20) @(negedge clk);
      n_total++;
      if (tx_obs.size() != 0) $display("FAIL mid_no_write: got %0d DATA writes want 0", tx_obs.size()); else n_pass++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish before 500us");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_tx_single();
      test_back_to_back();
      test_rx_single();
      test_rx_backpressure();
      test_arbitration();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
